// File: rtl/alu_seq_if.sv
// Handshake and operand bus between issue/writeback and the sequenced ALU.
interface alu_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       opcode;
    logic [WIDTH-1:0] param1;
    logic [WIDTH-1:0] param2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             err_illegal;
    logic             err_divzero;

    modport master (
        output in_valid, opcode, param1, param2, out_ready,
        input  in_ready, out_valid, result, err_illegal, err_divzero
    );

    modport slave (
        input  in_valid, opcode, param1, param2, out_ready,
        output in_ready, out_valid, result, err_illegal, err_divzero
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked integer ALU: single-cycle integer/logic/move ops plus an
// iterative restoring divider taking WIDTH cycles.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | ready for an operation (in_ready=1)
// DIV    | restoring divide iterating, one quotient bit per cycle
// DONE   | result/flags held on the bus until out_ready
module alu_seq #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic       clk,
    input  logic       reset,
    alu_seq_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] OP_DIV = 5'h1d;

    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] LOW12   = WIDTH'(12'hFFF);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LD  = CNT_W'(WIDTH);

    logic [1:0]       state_q;
    logic [WIDTH-1:0] result_q;
    logic             err_illegal_q;
    logic             err_divzero_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] count_q;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             alu_dz;
    logic             shift_big;
    logic [CNT_W-1:0] shamt;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_next;

    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.result      = result_q;
    assign bus.err_illegal = err_illegal_q;
    assign bus.err_divzero = err_divzero_q;

    // Shift amount is compared at full width so large B never aliases a small shift.
    assign shift_big = (bus.param2 >= WIDTH_V);
    assign shamt     = bus.param2[CNT_W-1:0];

    // Single-cycle result and flags for whatever is on the input bus.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        alu_dz  = 1'b0;
        case (bus.opcode)
            5'h18, 5'h19: alu_res = bus.param1 + bus.param2;
            5'h1a, 5'h1b: alu_res = bus.param1 - bus.param2;
            5'h1c:        alu_res = bus.param1 * bus.param2;
            OP_DIV: begin
                if (bus.param2 == '0) begin
                    alu_res = '1;
                    alu_dz  = 1'b1;
                end
            end
            5'h00:        alu_res = bus.param1 & bus.param2;
            5'h01:        alu_res = bus.param1 | bus.param2;
            5'h02:        alu_res = bus.param1 ^ bus.param2;
            5'h03:        alu_res = ~bus.param1;
            5'h04, 5'h05: alu_res = shift_big ? '0 : (bus.param1 >> shamt);
            5'h06, 5'h07: alu_res = shift_big ? '0 : (bus.param1 << shamt);
            5'h11:        alu_res = bus.param1;
            5'h12:        alu_res = (bus.param1 & ~LOW12) | bus.param2;
            default:      alu_ill = 1'b1;
        endcase
    end

    // One restoring-divide step: the borrow bit of the trial subtract decides the quotient bit.
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, dvs_q};
        quo_next  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_next  = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    end

    // Control FSM, output registers and divider datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            result_q      <= '0;
            err_illegal_q <= 1'b0;
            err_divzero_q <= 1'b0;
            quo_q         <= '0;
            rem_q         <= '0;
            dvs_q         <= '0;
            count_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.opcode == OP_DIV && bus.param2 != '0) begin
                            quo_q   <= bus.param1;
                            dvs_q   <= bus.param2;
                            rem_q   <= '0;
                            count_q <= CNT_LD;
                            state_q <= S_DIV;
                        end else begin
                            result_q      <= alu_res;
                            err_illegal_q <= alu_ill;
                            err_divzero_q <= alu_dz;
                            state_q       <= S_DONE;
                        end
                    end
                end
                S_DIV: begin
                    quo_q   <= quo_next;
                    rem_q   <= rem_next;
                    count_q <= count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
                        result_q      <= quo_next;
                        err_illegal_q <= 1'b0;
                        err_divzero_q <= 1'b0;
                        state_q       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
